// File: rtl/uart_pkg.sv
// Shared UART constants: baud divider, register map, status bits and receiver states.
package uart_pkg;

  localparam int DEFAULT_DIVIDER = 104;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;

  localparam int ST_AVAIL   = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_FRAME   = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous byte FIFO; the head entry is visible on pop_data while not empty.
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a small receive FIFO and a DATA/STATUS read port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIVIDER    = DEFAULT_DIVIDER,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_en,
  input  logic [1:0] addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rx_avail
);

  localparam int CW = $clog2(DIVIDER);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIVIDER / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIVIDER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          rx_meta_reg, rx_s_reg;
  rx_state_t     state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bitn_reg, bitn_next;
  logic [7:0]    shift_reg, shift_next;
  logic          push, frame_set;
  logic          overrun_reg, frame_err_reg;
  logic [7:0]    rd_data_reg;
  logic          rd_valid_reg;
  logic          fifo_full, fifo_empty, pop;
  logic [7:0]    pop_data;
  logic          status_clr, overrun_set;
  logic [7:0]    status_word, rd_word;
  logic          evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bitn_reg  <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bitn_reg  <= bitn_next;
      shift_reg <= shift_next;
    end
  end

  assign evt = (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = (state_reg == IDLE) ? cnt_reg : cnt_reg - CNT_ONE;
    bitn_next  = bitn_reg;
    shift_next = shift_reg;
    push       = 1'b0;
    frame_set  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          cnt_next   = CNT_HALF;
          state_next = START;
        end
      end
      START: begin
        if (evt) begin
          if (!rx_s_reg) begin
            cnt_next   = CNT_FULL;
            bitn_next  = '0;
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (evt) begin
          shift_next = {rx_s_reg, shift_reg[7:1]};
          cnt_next   = CNT_FULL;
          if (bitn_reg == 3'd7) state_next = STOP;
          else                  bitn_next  = bitn_reg + 3'd1;
        end
      end
      STOP: begin
        if (evt) begin
          if (rx_s_reg) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            frame_set  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        // Stay here until the line releases so a long break counts once.
        if (rx_s_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shift_reg),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_avail    = !fifo_empty;
  assign pop         = rd_en && (addr == ADDR_DATA) && !fifo_empty;
  assign status_clr  = rd_en && (addr == ADDR_STATUS);
  assign overrun_set = push && fifo_full && !pop;

  always_comb begin
    status_word             = '0;
    status_word[ST_AVAIL]   = rx_avail;
    status_word[ST_OVERRUN] = overrun_reg;
    status_word[ST_FRAME]   = frame_err_reg;
    rd_word                 = 8'h00;
    if (rd_en) begin
      case (addr)
        ADDR_DATA:   rd_word = fifo_empty ? 8'h00 : pop_data;
        ADDR_STATUS: rd_word = status_word;
        default:     rd_word = 8'h00;
      endcase
    end
  end

  // A set in the same cycle as a clearing STATUS read wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      rd_data_reg   <= '0;
      rd_valid_reg  <= 1'b0;
    end else begin
      overrun_reg   <= overrun_set | (overrun_reg & ~status_clr);
      frame_err_reg <= frame_set | (frame_err_reg & ~status_clr);
      rd_data_reg   <= rd_word;
      rd_valid_reg  <= rd_en;
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized and directed checks of uart_rx against a queue-based receive model.
module tb_uart_rx;

  localparam int DIV   = 104;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rx_avail;

  uart_rx #(.DIVIDER(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rd_en    (rd_en),
    .addr     (addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rx_avail (rx_avail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: bytes received and not yet read, plus the two sticky flags.
  byte unsigned exp_q[$];
  bit           exp_over  = 1'b0;
  bit           exp_frame = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic drive_bit(logic v);
    rx = v;
    idle_cycles(DIV);
  endtask

  task automatic send_frame(byte unsigned b, bit stop);
    $display("frame 0x%02h stop=%0d", b, stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    check("avail_before_stop", rx_avail, exp_q.size() != 0);
    drive_bit(stop);
    if (stop) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      exp_over = 1'b1;
    end else begin
      exp_frame = 1'b1;
    end
    rx = 1'b1;
    check("avail_after_frame", rx_avail, exp_q.size() != 0);
  endtask

  function automatic logic [7:0] model_read(logic [1:0] a);
    logic [7:0] e;
    e = 8'h00;
    if (a == 2'd0) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
    end else if (a == 2'd1) begin
      e = {5'b0, exp_frame, exp_over, exp_q.size() != 0};
      exp_over  = 1'b0;
      exp_frame = 1'b0;
    end
    return e;
  endfunction

  task automatic bus_read(logic [1:0] a, string tag);
    logic [7:0] e;
    e = model_read(a);
    @(negedge clk);
    rd_en = 1'b1;
    addr  = a;
    @(negedge clk);
    rd_en = 1'b0;
    addr  = 2'd0;
    $display("read addr=%0d data=0x%02h exp=0x%02h", a, rd_data, e);
    check({tag, "_valid"}, rd_valid, 1'b1);
    check(tag, rd_data, e);
    @(negedge clk);
    check({tag, "_valid_drop"}, rd_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] e0, e1;
    // Reset state
    idle_cycles(3);
    #1;
    check("rst_rd_data", rd_data, 8'h00);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_avail", rx_avail, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(5);

    // Single frame
    send_frame(8'h55, 1'b1);
    bus_read(2'd0, "data_55");
    check("avail_fall", rx_avail, 1'b0);

    // Back-to-back frames, then back-to-back DATA reads
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    bus_read(2'd2, "reserved2");
    bus_read(2'd3, "reserved3");
    e0 = model_read(2'd0);
    e1 = model_read(2'd0);
    @(negedge clk);
    rd_en = 1'b1;
    addr  = 2'd0;
    @(negedge clk);
    check("b2b_valid0", rd_valid, 1'b1);
    check("b2b_data0", rd_data, e0);
    @(negedge clk);
    rd_en = 1'b0;
    check("b2b_valid1", rd_valid, 1'b1);
    check("b2b_data1", rd_data, e1);
    $display("back-to-back reads 0x%02h 0x%02h", e0, e1);
    bus_read(2'd1, "status_b2b");

    // Glitch shorter than half a bit
    rx = 1'b0;
    idle_cycles(20);
    rx = 1'b1;
    idle_cycles(2 * DIV);
    bus_read(2'd1, "status_glitch");
    check("glitch_avail", rx_avail, 1'b0);

    // Bad stop bit
    send_frame(8'h81, 1'b0);
    idle_cycles(DIV);
    bus_read(2'd1, "status_frame");
    bus_read(2'd1, "status_frame_clr");

    // 30-bit break gives one frame error
    $display("break 30 bits");
    rx = 1'b0;
    idle_cycles(30 * DIV);
    rx = 1'b1;
    exp_frame = 1'b1;
    idle_cycles(2 * DIV);
    bus_read(2'd1, "status_break");
    bus_read(2'd1, "status_break_clr");
    check("break_avail", rx_avail, 1'b0);

    // Overrun
    for (int i = 1; i <= 5; i++) send_frame(byte'(i), 1'b1);
    bus_read(2'd1, "status_overrun");
    for (int i = 0; i < 5; i++) bus_read(2'd0, "data_overrun");

    // Reset in the middle of data bit 3, with a byte already queued
    send_frame(8'h11, 1'b1);
    $display("frame 0x99 interrupted by reset");
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b1;
    idle_cycles(DIV / 2 - 4);
    bus_read(2'd1, "status_pre_reset");
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_data", rd_data, 8'h00);
    check("mid_rst_rd_valid", rd_valid, 1'b0);
    check("mid_rst_avail", rx_avail, 1'b0);
    exp_q.delete();
    exp_over  = 1'b0;
    exp_frame = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(2 * DIV);
    check("post_rst_avail", rx_avail, 1'b0);
    send_frame(8'h7E, 1'b1);
    bus_read(2'd0, "data_7e");
    bus_read(2'd1, "status_7e");

    // Randomized frames and reads
    for (int n = 0; n < 14; n++) begin
      byte unsigned b;
      bit           stop;
      b    = byte'($urandom_range(0, 255));
      stop = ($urandom_range(0, 7) != 0);
      idle_cycles($urandom_range(0, 3) * (DIV / 4));
      send_frame(b, stop);
      if (!stop) idle_cycles(4);
      for (int r = $urandom_range(0, 2); r > 0; r--) begin
        bus_read(2'($urandom_range(0, 3)), "rand_read");
      end
    end
    bus_read(2'd1, "final_status");
    while (exp_q.size() != 0) bus_read(2'd0, "final_drain");
    bus_read(2'd0, "final_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
